core_sensor_status: RTL and testbench

Avalon-MM slave input port that samples sensor status lines (fault/ready) from the sensor front-end. It synchronises and debounces each line, then latches qualifying edges into a write-1-to-clear capture register. A maskable level interrupt goes to the Nios II. It is the read-side counterpart of the sensor-reset output port on the same slave bus.

---
 rtl/core_sensor_status.sv | 172 +++++++++++++++++
 tb/tb_core_sensor_status.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sensor_status.sv
// core_sensor_status: Avalon-MM slave input port for sensor status lines.
// Each raw line is synchronised, debounced and edge-detected.
// Qualifying edges latch into a write-1-to-clear capture register.
// A maskable level interrupt is raised from the captured edges.
//
// Ports:
//   clk        system clock
//   reset      asynchronous reset, active-high
//   address    register select (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect slave select (qualifies writes only)
//   write_n    write strobe, active-low
//   writedata  write data, only [WIDTH-1:0] used
//   readdata   registered read data, latency 1
//   in_port    raw asynchronous sensor status lines
//   irq        level interrupt, active-high

// Per-line synchroniser, debouncer and edge detector.
module core_sensor_status_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic stable,
  output logic edge_evt
);
  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic                   prev_q, prev_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
    prev_d = stable_q;
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb stable_d = sync_out;
    end else begin : g_deb
      logic [CW-1:0] cnt_q, cnt_d;

      // Counter runs only while the synchronised level disagrees with the
      // accepted level; any agreeing sample restarts the qualification.
      always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_out == stable_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d = sync_out;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_evt = stable_q & ~prev_q;
      1:       edge_evt = ~stable_q & prev_q;
      default: edge_evt = stable_q ^ prev_q;
    endcase
  end

  assign stable = stable_q;
endmodule

module core_sensor_status #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic [WIDTH-1:0] clr_mask;
  logic             unused_wd;

  // Upper writedata bits are don't-care when WIDTH < 32.
  assign unused_wd = ^writedata;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      core_sensor_status_lane #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .EDGE_TYPE      (EDGE_TYPE)
      ) u_lane (
        .clk     (clk),
        .reset   (reset),
        .in_bit  (in_port[i]),
        .stable  (stable[i]),
        .edge_evt(edge_evt[i])
      );
    end
  endgenerate

  assign wr_en    = chipselect & ~write_n;
  assign clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_en && address == 2'd2) irqmask_d = writedata[WIDTH-1:0];
    // A new event outranks a simultaneous clear so no edge is lost.
    edgecap_d = edge_evt | (edgecap_q & ~clr_mask);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = stable;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);
endmodule

// File: tb/tb_core_sensor_status.sv
// Bench for core_sensor_status: three instances (rising, falling, any edge)
// share one bus and one set of sensor lines, checked against a
// window-based behavioural model plus hand-derived constants.
module tb_core_sensor_status;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   rd [3];
  logic          irq [3];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  generate
    for (genvar e = 0; e < 3; e++) begin : g_dut
      core_sensor_status #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(e)
      ) u_dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[e]),
        .in_port(in_port), .irq(irq[e])
      );
    end
  endgenerate

  // Reference model: a line's accepted level flips once the last DB
  // synchronised samples all disagree with it.
  logic [W-1:0] m_sp [SS];
  logic [W-1:0] m_hist [$];
  logic [W-1:0] m_stable, m_prev, m_mask;
  logic [W-1:0] m_ec [3];
  logic [31:0]  m_rd [3];

  task automatic model_step();
    logic [W-1:0] clr, ev, nst, smp;
    bit all_diff;
    if (reset) begin
      foreach (m_sp[i]) m_sp[i] = '0;
      m_hist.delete();
      m_stable = '0; m_prev = '0; m_mask = '0;
      for (int e = 0; e < 3; e++) begin m_ec[e] = '0; m_rd[e] = '0; end
      return;
    end
    clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int e = 0; e < 3; e++) begin
      case (address)
        2'd0:    m_rd[e] = 32'(m_stable);
        2'd2:    m_rd[e] = 32'(m_mask);
        2'd3:    m_rd[e] = 32'(m_ec[e]);
        default: m_rd[e] = '0;
      endcase
      case (e)
        0:       ev = m_stable & ~m_prev;
        1:       ev = ~m_stable & m_prev;
        default: ev = m_stable ^ m_prev;
      endcase
      m_ec[e] = ev | (m_ec[e] & ~clr);
    end
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_hist.push_back(m_sp[SS-1]);
    if (m_hist.size() > DB) void'(m_hist.pop_front());
    nst = m_stable;
    if (m_hist.size() == DB) begin
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) begin
          smp = m_hist[j];
          if (smp[b] == m_stable[b]) all_diff = 1'b0;
        end
        if (all_diff) nst[b] = ~m_stable[b];
      end
    end
    m_prev   = m_stable;
    m_stable = nst;
    for (int i = SS - 1; i > 0; i--) m_sp[i] = m_sp[i-1];
    m_sp[0] = in_port;
  endtask

  function automatic logic m_irq(int e);
    return |(m_ec[e] & m_mask);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_port = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      for (int e = 0; e < 3; e++) begin
        n_cmp++;
        if (rd[e] !== 32'h0 || irq[e] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset inst%0d addr%0d: got rd=%h irq=%b want rd=0 irq=0", e, a, rd[e], irq[e]);
        end
      end
    end
    bus_write(2'd0, 32'hFF);
    address = 2'd0;
    tick();
    n_cmp++;
    if (rd[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL ro_data: got %h want 00000000", rd[0]);
    end
  endtask

  task automatic test_rise();
    in_port = 8'h01; address = 2'd0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      n_cmp++;
      if (rd[0] !== ((n >= 7) ? 32'h1 : 32'h0) || rd[0] !== m_rd[0]) begin
        n_fail++;
        $display("FAIL rise_data tick%0d: got %h want %h", n, rd[0], (n >= 7) ? 1 : 0);
      end
    end
    address = 2'd3;
    tick();
    n_cmp++;
    if (rd[0] !== 32'h1 || rd[1] !== 32'h0 || rd[2] !== 32'h1) begin
      n_fail++;
      $display("FAIL rise_ec: got %h/%h/%h want 1/0/1", rd[0], rd[1], rd[2]);
    end
    n_cmp++;
    if (irq[0] !== 1'b0 || irq[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_irq_masked: got %b/%b want 0/0", irq[0], irq[2]);
    end
    bus_write(2'd2, 32'h01);
    n_cmp++;
    if (irq[0] !== 1'b1 || irq[1] !== 1'b0 || irq[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_irq: got %b/%b/%b want 1/0/1", irq[0], irq[1], irq[2]);
    end
  endtask

  task automatic test_glitch();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h09;
    repeat (3) tick();
    in_port = 8'h01;
    repeat (10) tick();
    address = 2'd3;
    tick();
    n_cmp++;
    if (rd[0] !== 32'h0 || rd[0] !== m_rd[0] || irq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_ec: got %h irq=%b want 00000000 irq=0", rd[0], irq[0]);
    end
    in_port = 8'h09;
    repeat (5) tick();
    in_port = 8'h01;
    repeat (12) tick();
    address = 2'd3;
    tick();
    n_cmp++;
    if (rd[0] !== 32'h08 || rd[0] !== m_rd[0]) begin
      n_fail++;
      $display("FAIL pulse_ec: got %h want 00000008", rd[0]);
    end
  endtask

  task automatic test_w1c();
    in_port = 8'h00;
    repeat (8) tick();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h09;
    repeat (9) tick();
    bus_write(2'd2, 32'h09);
    address = 2'd3;
    tick();
    n_cmp++;
    if (rd[0] !== 32'h09 || irq[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_setup: got %h irq=%b want 00000009 irq=1", rd[0], irq[0]);
    end
    bus_write(2'd3, 32'h01);
    address = 2'd3;
    tick();
    n_cmp++;
    if (rd[0] !== 32'h08 || irq[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_bit0: got %h irq=%b want 00000008 irq=1", rd[0], irq[0]);
    end
    bus_write(2'd3, 32'h08);
    address = 2'd3;
    tick();
    n_cmp++;
    if (rd[0] !== 32'h00 || irq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_bit3: got %h irq=%b want 00000000 irq=0", rd[0], irq[0]);
    end
    // Clear of bit 1 lands on the same edge that captures its rise.
    in_port = 8'h0B;
    repeat (6) tick();
    bus_write(2'd3, 32'h02);
    address = 2'd3;
    tick();
    n_cmp++;
    if (rd[0] !== 32'h02 || rd[0] !== m_rd[0]) begin
      n_fail++;
      $display("FAIL set_beats_clear: got %h want 00000002", rd[0]);
    end
  endtask

  task automatic test_edge_types();
    in_port = 8'h00;
    repeat (10) tick();
    bus_write(2'd3, 32'hFF);
    in_port = 8'hFF;
    repeat (10) tick();
    in_port = 8'hF0;
    repeat (10) tick();
    address = 2'd3;
    tick();
    n_cmp++;
    if (rd[1] !== 32'h0F || rd[0] !== m_rd[0] || rd[2] !== 32'hFF) begin
      n_fail++;
      $display("FAIL edge_fall: got %h/%h/%h want %h/0000000f/000000ff", rd[0], rd[1], rd[2], m_rd[0]);
    end
    bus_write(2'd3, 32'hFF);
    in_port = 8'h70;
    repeat (10) tick();
    address = 2'd3;
    tick();
    n_cmp++;
    if (rd[2] !== 32'h80 || rd[1] !== 32'h80 || rd[0] !== 32'h00) begin
      n_fail++;
      $display("FAIL edge_any_fall: got %h/%h/%h want 0/80/80", rd[0], rd[1], rd[2]);
    end
    bus_write(2'd3, 32'hFF);
    in_port = 8'hF0;
    repeat (10) tick();
    address = 2'd3;
    tick();
    n_cmp++;
    if (rd[2] !== 32'h80 || rd[1] !== 32'h00 || rd[0] !== 32'h80) begin
      n_fail++;
      $display("FAIL edge_any_rise: got %h/%h/%h want 80/0/80", rd[0], rd[1], rd[2]);
    end
  endtask

  task automatic test_reset_mid();
    in_port = 8'h00;
    repeat (10) tick();
    in_port = 8'h04;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    address = 2'd0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      n_cmp++;
      if (rd[0] !== ((n >= 7) ? 32'h4 : 32'h0) || rd[0] !== m_rd[0]) begin
        n_fail++;
        $display("FAIL rst_mid_data tick%0d: got %h want %h", n, rd[0], (n >= 7) ? 4 : 0);
      end
    end
    address = 2'd2;
    tick();
    n_cmp++;
    if (rd[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_mask: got %h want 00000000", rd[0]);
    end
    address = 2'd3;
    tick();
    n_cmp++;
    if (rd[0] !== 32'h04 || irq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ec: got %h irq=%b want 00000004 irq=0", rd[0], irq[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(5) == 0) in_port = in_port ^ W'($urandom);
      chipselect = ($urandom_range(3) == 0);
      write_n    = 1'($urandom_range(1));
      address    = 2'($urandom_range(3));
      writedata  = $urandom;
      tick();
      for (int e = 0; e < 3; e++) begin
        n_cmp++;
        if (rd[e] !== m_rd[e]) begin
          n_fail++;
          $display("FAIL rnd_rd inst%0d it%0d: got %h want %h", e, it, rd[e], m_rd[e]);
        end
        n_cmp++;
        if (irq[e] !== m_irq(e)) begin
          n_fail++;
          $display("FAIL rnd_irq inst%0d it%0d: got %b want %b", e, it, irq[e], m_irq(e));
        end
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_w1c();
    test_edge_types();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
